regfile_wr_arbiter: RTL and testbench

Write-side front end for the three-ported register file: merges the single-cycle pipeline writeback stream with results from the multi-cycle units (load/mult/div) onto the one write port (we3/wa3/wd3). Multi-cycle results are buffered in a small FIFO. A starvation counter briefly stalls the pipeline so buffered results are not held off indefinitely. A 32-entry pending-write scoreboard tells the decode stage which source registers still await a multi-cycle result.

---
 rtl/regfile_wr_arbiter.sv | 129 ++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter.sv
// Write-port arbiter for the three-ported register file: merges single-cycle writeback
// with buffered multi-cycle results, with anti-starvation stall and a pending-write scoreboard.
module regfile_wr_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        a_valid,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  output logic        stall_a,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_addr,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic        busy1,
  output logic        busy2,
  output logic        we3,
  output logic [4:0]  wa3,
  output logic [31:0] wd3,
  output logic        issue_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT    = CW'(STARVE_LIMIT);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [4:0]    buf_addr [DEPTH];
  logic [31:0]   buf_data [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [CW-1:0] starve_cnt;
  logic [31:0]   busy;
  logic [31:0]   busy_next;
  logic          err_q;

  logic          empty;
  logic          full;
  logic          push;
  logic          grant_a;
  logic          grant_b;
  logic [4:0]    head_addr;
  logic [31:0]   head_data;

  assign empty     = (count == '0);
  assign full      = (count == FULL_CNT);
  assign b_ready   = ~full;
  assign push      = b_valid & ~full;
  assign head_addr = buf_addr[rd_ptr];
  assign head_data = buf_data[rd_ptr];

  // stall is decoded purely from registered state so it never loops through a_valid
  assign stall_a = (starve_cnt == LIMIT) & ~empty;
  assign grant_a = ~stall_a & a_valid;
  assign grant_b = ~empty & (stall_a | ~a_valid);

  assign busy1     = busy[ra1];
  assign busy2     = busy[ra2];
  assign issue_err = err_q;

  always_comb begin
    we3 = 1'b0;
    wa3 = '0;
    wd3 = '0;
    if (grant_a) begin
      we3 = (a_addr != 5'd0);
      wa3 = a_addr;
      wd3 = a_data;
    end else if (grant_b) begin
      we3 = (head_addr != 5'd0);
      wa3 = head_addr;
      wd3 = head_data;
    end
  end

  // a same-cycle issue overrides the commit clear, so set is applied last
  always_comb begin
    busy_next = busy;
    if (grant_b)
      busy_next[head_addr] = 1'b0;
    if (issue_valid)
      busy_next[issue_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      busy       <= '0;
      err_q      <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (grant_b)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, grant_b})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (empty || grant_b)
        starve_cnt <= '0;
      else if (grant_a)
        starve_cnt <= starve_cnt + 1'b1;
      busy <= busy_next;
      if (issue_valid && (issue_addr != 5'd0) && busy[issue_addr])
        err_q <= 1'b1;
    end
  end

  // result storage carries no reset; occupancy is tracked by count alone
  always_ff @(posedge clk) begin
    if (push) begin
      buf_addr[wr_ptr] <= b_addr;
      buf_data[wr_ptr] <= b_data;
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: inputs change on the falling edge, outputs are checked 1 ns later.
module tb_regfile_wr_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        a_valid;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic        stall_a;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic        issue_valid;
  logic [4:0]  issue_addr;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic        busy1;
  logic        busy2;
  logic        we3;
  logic [4:0]  wa3;
  logic [31:0] wd3;
  logic        issue_err;

  int checks = 0;
  int fails  = 0;

  regfile_wr_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .stall_a(stall_a),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .ra1(ra1), .ra2(ra2), .busy1(busy1), .busy2(busy2),
    .we3(we3), .wa3(wa3), .wd3(wd3), .issue_err(issue_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
    issue_valid = 1'b0; issue_addr = '0; ra1 = '0; ra2 = '0;
    nxt(); nxt();
    reset_n = 1'b1;
    #1;
    chk("rst_b_ready", b_ready, 1);
    chk("rst_stall_a", stall_a, 0);
    chk("rst_we3", we3, 0);
    chk("rst_issue_err", issue_err, 0);
    for (int r = 0; r < 32; r++) begin
      ra1 = 5'(r); ra2 = 5'(31 - r);
      #1;
      chk($sformatf("rst_busy1_r%0d", r), busy1, 0);
      chk($sformatf("rst_busy2_r%0d", 31 - r), busy2, 0);
    end

    // A only
    nxt(); a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEADBEEF; #1;
    chk("a_we3", we3, 1);
    chk("a_wa3", wa3, 5);
    chk("a_wd3", wd3, 32'hDEADBEEF);
    nxt(); a_addr = 5'd0; #1;
    chk("a_r0_we3", we3, 0);
    nxt(); a_valid = 1'b0; #1;
    chk("idle_we3", we3, 0);

    // B only with scoreboard
    issue_valid = 1'b1; issue_addr = 5'd9; ra1 = 5'd9;
    nxt(); issue_valid = 1'b0;
    b_valid = 1'b1; b_addr = 5'd9; b_data = 32'h1234; #1;
    chk("b_busy1_set", busy1, 1);
    chk("b_no_bypass_we3", we3, 0);
    nxt(); b_valid = 1'b0; #1;
    chk("b_we3", we3, 1);
    chk("b_wa3", wa3, 9);
    chk("b_wd3", wd3, 32'h1234);
    chk("b_busy1_commit", busy1, 1);
    nxt(); #1;
    chk("b_busy1_clear", busy1, 0);
    chk("b_after_we3", we3, 0);

    // Starvation: one buffered entry against continuous A traffic
    b_valid = 1'b1; b_addr = 5'd3; b_data = 32'hAAAA;
    a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h10;
    nxt(); b_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      a_data = 32'h10 + 32'(c);
      #1;
      chk($sformatf("starve_c%0d_stall", c), stall_a, 0);
      chk($sformatf("starve_c%0d_wd3", c), wd3, 32'h10 + 32'(c));
      nxt();
    end
    a_addr = 5'd2; a_data = 32'h22; #1;
    chk("starve_stall", stall_a, 1);
    chk("starve_b_wa3", wa3, 3);
    chk("starve_b_wd3", wd3, 32'hAAAA);
    nxt(); #1;
    chk("starve_after_stall", stall_a, 0);
    chk("starve_a_wa3", wa3, 2);
    chk("starve_a_wd3", wd3, 32'h22);

    // Full buffer
    nxt(); a_addr = 5'd4; a_data = 32'h44;
    b_valid = 1'b1; b_addr = 5'd10; b_data = 32'h100; #1;
    chk("full_f1_ready", b_ready, 1);
    nxt(); b_addr = 5'd11; b_data = 32'h101; #1;
    chk("full_f2_ready", b_ready, 1);
    nxt(); b_addr = 5'd12; b_data = 32'h102; #1;
    chk("full_f3_ready", b_ready, 0);
    chk("full_f3_a_wa3", wa3, 4);
    nxt(); b_valid = 1'b0; a_valid = 1'b0; #1;
    chk("full_pop1_wa3", wa3, 10);
    chk("full_pop1_wd3", wd3, 32'h100);
    chk("full_pop1_ready", b_ready, 0);
    nxt(); #1;
    chk("full_pop2_ready", b_ready, 1);
    chk("full_pop2_wa3", wa3, 11);
    chk("full_pop2_wd3", wd3, 32'h101);
    nxt(); #1;
    chk("full_third_dropped", we3, 0);

    // Same-cycle issue and commit on r7
    issue_valid = 1'b1; issue_addr = 5'd7; ra2 = 5'd7;
    nxt(); issue_valid = 1'b0;
    b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h77; #1;
    chk("sc_busy2_set", busy2, 1);
    nxt(); b_valid = 1'b0; issue_valid = 1'b1; issue_addr = 5'd7; #1;
    chk("sc_commit_wa3", wa3, 7);
    chk("sc_commit_we3", we3, 1);
    nxt(); issue_valid = 1'b0; #1;
    chk("sc_busy2_set_wins", busy2, 1);

    // Reset clears scoreboard
    reset_n = 1'b0;
    nxt(); reset_n = 1'b1; #1;
    chk("rst2_busy2", busy2, 0);
    chk("rst2_issue_err", issue_err, 0);

    // Sticky issue error
    issue_valid = 1'b1; issue_addr = 5'd13; ra1 = 5'd13;
    nxt(); #1;
    chk("err_first_issue", issue_err, 0);
    nxt(); issue_valid = 1'b0; #1;
    chk("err_set", issue_err, 1);
    chk("err_busy1", busy1, 1);
    b_valid = 1'b1; b_addr = 5'd13; b_data = 32'h1313;
    nxt(); b_valid = 1'b0; #1;
    chk("err_commit_wa3", wa3, 13);
    chk("err_sticky1", issue_err, 1);
    nxt(); #1;
    chk("err_sticky2", issue_err, 1);
    chk("err_busy1_clear", busy1, 0);

    // Reset mid-operation discards a buffered result
    a_valid = 1'b1; a_addr = 5'd6; a_data = 32'h66;
    b_valid = 1'b1; b_addr = 5'd20; b_data = 32'h2020;
    nxt(); b_valid = 1'b0; a_valid = 1'b0; reset_n = 1'b0;
    nxt(); reset_n = 1'b1; #1;
    chk("rst3_we3", we3, 0);
    chk("rst3_ready", b_ready, 1);
    chk("rst3_issue_err", issue_err, 0);
    nxt(); #1;
    chk("rst3_still_empty", we3, 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
